// File: rtl/vga_dither_out_if.sv
// Pixel bus between the pattern controller and the dithered output pins.
// W is the per-channel colour width: 8 on the input side, OUT_BITS on the output side.
interface vga_dither_out_if #(
  parameter int W = 8
);
  logic [W-1:0] r;
  logic [W-1:0] g;
  logic [W-1:0] b;
  logic         hsync;
  logic         vsync;
  logic         hblank;
  logic         vblank;

  modport master (output r, g, b, hsync, vsync, hblank, vblank);
  modport slave  (input  r, g, b, hsync, vsync, hblank, vblank);
endinterface

// File: rtl/vga_dither_out.sv
// Reduces 24-bit RGB to OUT_BITS per channel with 4x4 ordered dither and an optional per-frame phase shift.
// Fixed 2-clk latency for colour, sync and blank; no backpressure, one pixel per clk.
module vga_dither_out #(
  parameter int OUT_BITS = 2,
  parameter bit TEMPORAL = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dither_en,
  vga_dither_out_if.slave  pix_i,
  vga_dither_out_if.master pix_o
);
  localparam int DROP = 8 - OUT_BITS;

  logic [1:0] xph_q, xph_d;
  logic [1:0] yph_q, yph_d;
  logic [1:0] fcnt_q, fcnt_d;
  logic       hb_prev_q, vb_prev_q;
  logic [1:0] xi, yi;
  logic [7:0] thr_d;

  logic [7:0] r1_q, g1_q, b1_q, t1_q;
  logic       hs1_q, vs1_q, hb1_q, vb1_q, blank1_q;

  logic [OUT_BITS-1:0] r2_q, g2_q, b2_q;
  logic [OUT_BITS-1:0] r2_d, g2_d, b2_d;
  logic                hs2_q, vs2_q, hb2_q, vb2_q;

  function automatic logic [3:0] bayer(input logic [1:0] y, input logic [1:0] x);
    logic [3:0] v;
    case ({y, x})
      4'h0: v = 4'd0;   4'h1: v = 4'd8;   4'h2: v = 4'd2;   4'h3: v = 4'd10;
      4'h4: v = 4'd12;  4'h5: v = 4'd4;   4'h6: v = 4'd14;  4'h7: v = 4'd6;
      4'h8: v = 4'd3;   4'h9: v = 4'd11;  4'hA: v = 4'd1;   4'hB: v = 4'd9;
      4'hC: v = 4'd15;  4'hD: v = 4'd7;   4'hE: v = 4'd13;  default: v = 4'd5;
    endcase
    return v;
  endfunction

  // A carry out of the 8-bit add saturates to full scale so bright pixels never wrap to black.
  function automatic logic [OUT_BITS-1:0] quant(input logic [7:0] c, input logic [7:0] t);
    logic [8:0] s;
    s = {1'b0, c} + {1'b0, t};
    return s[8] ? {OUT_BITS{1'b1}} : OUT_BITS'(s >> DROP);
  endfunction

  always_comb begin
    xph_d = pix_i.hblank ? 2'd0 : xph_q + 2'd1;
    yph_d = yph_q;
    if (pix_i.vblank) begin
      yph_d = 2'd0;
    end else if (pix_i.hblank && !hb_prev_q) begin
      yph_d = yph_q + 2'd1;
    end
    fcnt_d = fcnt_q;
    if (TEMPORAL && pix_i.vblank && !vb_prev_q) begin
      fcnt_d = fcnt_q + 2'd1;
    end
    xi    = xph_q + {fcnt_q[0], 1'b0};
    yi    = yph_q + {fcnt_q[1], 1'b0};
    thr_d = dither_en ? ({4'd0, bayer(yi, xi)} << (DROP - 4)) : 8'd0;
  end

  always_comb begin
    r2_d = blank1_q ? '0 : quant(r1_q, t1_q);
    g2_d = blank1_q ? '0 : quant(g1_q, t1_q);
    b2_d = blank1_q ? '0 : quant(b1_q, t1_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      xph_q     <= '0;
      yph_q     <= '0;
      fcnt_q    <= '0;
      hb_prev_q <= 1'b0;
      vb_prev_q <= 1'b0;
      r1_q      <= '0;
      g1_q      <= '0;
      b1_q      <= '0;
      t1_q      <= '0;
      hs1_q     <= 1'b0;
      vs1_q     <= 1'b0;
      hb1_q     <= 1'b0;
      vb1_q     <= 1'b0;
      blank1_q  <= 1'b0;
      r2_q      <= '0;
      g2_q      <= '0;
      b2_q      <= '0;
      hs2_q     <= 1'b0;
      vs2_q     <= 1'b0;
      hb2_q     <= 1'b0;
      vb2_q     <= 1'b0;
    end else begin
      xph_q     <= xph_d;
      yph_q     <= yph_d;
      fcnt_q    <= fcnt_d;
      hb_prev_q <= pix_i.hblank;
      vb_prev_q <= pix_i.vblank;
      r1_q      <= pix_i.r;
      g1_q      <= pix_i.g;
      b1_q      <= pix_i.b;
      t1_q      <= thr_d;
      hs1_q     <= pix_i.hsync;
      vs1_q     <= pix_i.vsync;
      hb1_q     <= pix_i.hblank;
      vb1_q     <= pix_i.vblank;
      blank1_q  <= pix_i.hblank | pix_i.vblank;
      r2_q      <= r2_d;
      g2_q      <= g2_d;
      b2_q      <= b2_d;
      hs2_q     <= hs1_q;
      vs2_q     <= vs1_q;
      hb2_q     <= hb1_q;
      vb2_q     <= vb1_q;
    end
  end

  assign pix_o.r      = r2_q;
  assign pix_o.g      = g2_q;
  assign pix_o.b      = b2_q;
  assign pix_o.hsync  = hs2_q;
  assign pix_o.vsync  = vs2_q;
  assign pix_o.hblank = hb2_q;
  assign pix_o.vblank = vb2_q;
endmodule

// File: tb/tb_vga_dither_out.sv
// Bench for vga_dither_out (OUT_BITS=2, TEMPORAL=1): directed pixels with hand-computed results,
// queued at issue time and compared by an independent monitor two clocks later.
module tb_vga_dither_out;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic dither_en = 1'b0;

  vga_dither_out_if #(.W(8)) pix_in ();
  vga_dither_out_if #(.W(2)) pix_out ();

  vga_dither_out #(.OUT_BITS(2), .TEMPORAL(1'b1)) dut (
    .clk       (clk),
    .reset     (reset),
    .dither_en (dither_en),
    .pix_i     (pix_in),
    .pix_o     (pix_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         due;
    int         id;
    logic [9:0] v;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   id_n   = 0;

  function automatic logic [9:0] outv();
    return {pix_out.r, pix_out.g, pix_out.b, pix_out.hsync, pix_out.vsync, pix_out.hblank, pix_out.vblank};
  endfunction

  task automatic check(input string name, input int id, input logic [9:0] act, input logic [9:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s #%0d got {r,g,b,hs,vs,hb,vb}=%b want %b", name, id, act, req);
    end
  endtask

  // Outputs only change on posedge; sampling on negedge keeps the monitor clear of the edge.
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      check("pix", e.id, outv(), e.v);
    end
  end

  task automatic drive(input logic rs, input logic hb, input logic vb, input logic hs, input logic vs,
                       input logic de, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                       input logic [1:0] er, input logic [1:0] eg, input logic [1:0] eb);
    exp_t e;
    @(negedge clk);
    #1;
    reset         = rs;
    pix_in.hblank = hb;
    pix_in.vblank = vb;
    pix_in.hsync  = hs;
    pix_in.vsync  = vs;
    dither_en     = de;
    pix_in.r      = r;
    pix_in.g      = g;
    pix_in.b      = b;
    if (rs) begin
      sb.delete();
    end else begin
      e.due = cyc + 2;
      e.id  = id_n;
      e.v   = {er, eg, eb, hs, vs, hb, vb};
      sb.push_back(e);
    end
    id_n++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    pix_in.r = 8'hFF; pix_in.g = 8'hFF; pix_in.b = 8'hFF;
    pix_in.hsync = 1'b1; pix_in.vsync = 1'b1;
    pix_in.hblank = 1'b0; pix_in.vblank = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_state", 0, outv(), 10'd0);

    // Line 0 (fcnt=0, yph=0): T = {0,32,8,40} by xph
    drive(0, 0, 0, 1, 0, 1, 8'hBF, 8'h7F, 8'h00, 2'd2, 2'd1, 2'd0);
    drive(0, 0, 0, 0, 0, 1, 8'hBF, 8'h7F, 8'hE0, 2'd3, 2'd2, 2'd3);
    check("sync_zero_after_release", 0, outv(), 10'd0);
    drive(0, 0, 0, 0, 0, 0, 8'hBF, 8'h7F, 8'hFF, 2'd2, 2'd1, 2'd3);
    drive(0, 0, 0, 0, 0, 1, 8'h18, 8'h17, 8'h00, 2'd1, 2'd0, 2'd0);
    drive(0, 0, 0, 0, 0, 1, 8'h40, 8'h80, 8'hC0, 2'd1, 2'd2, 2'd3);
    // Horizontal blank with full-scale colour and an hsync pulse
    drive(0, 1, 0, 0, 0, 1, 8'hFF, 8'hFF, 8'hFF, 2'd0, 2'd0, 2'd0);
    drive(0, 1, 0, 1, 0, 1, 8'hFF, 8'hFF, 8'hFF, 2'd0, 2'd0, 2'd0);
    drive(0, 1, 0, 0, 0, 1, 8'hFF, 8'hFF, 8'hFF, 2'd0, 2'd0, 2'd0);
    // Line 1: T = {48,16,...}
    drive(0, 0, 0, 0, 0, 1, 8'h10, 8'h0F, 8'hFF, 2'd1, 2'd0, 2'd3);
    drive(0, 0, 0, 0, 0, 1, 8'h30, 8'h2F, 8'h80, 2'd1, 2'd0, 2'd2);
    drive(0, 1, 0, 0, 0, 1, 8'h00, 8'h00, 8'h00, 2'd0, 2'd0, 2'd0);
    // Line 2: T(xph=0) = 12
    drive(0, 0, 0, 0, 0, 1, 8'h34, 8'h33, 8'h00, 2'd1, 2'd0, 2'd0);
    drive(0, 1, 0, 0, 0, 1, 8'h00, 8'h00, 8'h00, 2'd0, 2'd0, 2'd0);
    // Line 3: T(xph=0) = 60, 0xFF saturates
    drive(0, 0, 0, 0, 0, 1, 8'h04, 8'h03, 8'hFF, 2'd1, 2'd0, 2'd3);
    // hblank and vblank rise together: fcnt -> 1, yph cleared
    drive(0, 1, 1, 0, 0, 1, 8'hFF, 8'hFF, 8'hFF, 2'd0, 2'd0, 2'd0);
    drive(0, 0, 1, 0, 1, 1, 8'hFF, 8'hFF, 8'hFF, 2'd0, 2'd0, 2'd0);
    drive(0, 1, 1, 0, 1, 1, 8'hFF, 8'hFF, 8'hFF, 2'd0, 2'd0, 2'd0);
    drive(0, 1, 0, 0, 0, 1, 8'hFF, 8'hFF, 8'hFF, 2'd0, 2'd0, 2'd0);
    // Frame 1: Bayer phase shifted by two columns, T = {8,40,...}
    drive(0, 0, 0, 0, 0, 1, 8'h3A, 8'h37, 8'hF8, 2'd1, 2'd0, 2'd3);
    drive(0, 0, 0, 0, 0, 1, 8'h18, 8'h17, 8'h00, 2'd1, 2'd0, 2'd0);
    // Reset mid-line discards in-flight pixels and restarts all phase counters
    drive(1, 0, 0, 1, 1, 1, 8'hFF, 8'hFF, 8'hFF, 2'd0, 2'd0, 2'd0);
    drive(0, 0, 0, 1, 0, 1, 8'h3A, 8'h37, 8'h41, 2'd0, 2'd0, 2'd1);
    check("reset_mid_line", 0, outv(), 10'd0);
    drive(0, 1, 0, 0, 0, 1, 8'h00, 8'h00, 8'h00, 2'd0, 2'd0, 2'd0);
    check("sync_zero_after_mid_reset", 0, outv(), 10'd0);
    drive(0, 1, 0, 0, 0, 1, 8'h00, 8'h00, 8'h00, 2'd0, 2'd0, 2'd0);

    repeat (4) @(negedge clk);
    #1;
    check("scoreboard_drained", 0, 10'(sb.size()), 10'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
